// File: rtl/rotor_pkg.sv
// rotor_pkg: shared definitions for the clocked rotor bank.
//   ALPHABET_SIZE / ROTOR_OUT_W : Enigma alphabet size and per-rotor output width.
//   state_t                     : control FSM encoding (IDLE, HOLD, RUN).
//   mod_inc                     : position increment with wrap at radix-1.
//   clamp_pos                   : maps out-of-range load values to 0.
package rotor_pkg;

    localparam int ALPHABET_SIZE = 26;
    localparam int ROTOR_OUT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic logic [ROTOR_OUT_W-1:0] mod_inc(
        input logic [ROTOR_OUT_W-1:0] pos,
        input int                     radix
    );
        if (int'(pos) >= radix - 1) begin
            return '0;
        end
        return pos + 8'd1;
    endfunction

    function automatic logic [ROTOR_OUT_W-1:0] clamp_pos(
        input logic [ROTOR_OUT_W-1:0] value,
        input int                     radix
    );
        if (int'(value) >= radix) begin
            return '0;
        end
        return value;
    endfunction

endpackage

// File: rtl/rotor_stage.sv
// rotor_stage: one rotor position register.
//   clk, reset   : clock, synchronous active-high reset (position -> 0).
//   load         : load init_pos (values >= RADIX load as 0).
//   init_pos     : 8-bit start position.
//   notch        : 8-bit turnover position; values >= RADIX never match.
//   adv          : advance enable (increment modulo RADIX this edge).
//   at_notch     : current position equals notch.
//   pos_out      : current position, zero-extended to 8 bits.
module rotor_stage
    import rotor_pkg::*;
#(
    parameter int RADIX   = 26,
    parameter int STATE_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [ROTOR_OUT_W-1:0] init_pos,
    input  logic [ROTOR_OUT_W-1:0] notch,
    input  logic                   adv,
    output logic                   at_notch,
    output logic [ROTOR_OUT_W-1:0] pos_out
);

    logic [STATE_W-1:0] pos_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else if (load) begin
            pos_q <= STATE_W'(clamp_pos(init_pos, RADIX));
        end else if (adv) begin
            pos_q <= STATE_W'(mod_inc(pos_out, RADIX));
        end
    end

    assign pos_out  = ROTOR_OUT_W'(pos_q);
    // pos_q is always < RADIX, so an out-of-range notch can never match.
    assign at_notch = (pos_out == notch);

endmodule

// File: rtl/clocked_rotor_bank.sv
// clocked_rotor_bank: stack of NUM_ROTORS modulo-RADIX rotors with notch carry.
//   clk, reset        : clock, synchronous active-high reset.
//   load              : load rotor_init_state and start snapshot (beats step/run).
//   rotor_init_state  : per-rotor start position, rotor i at [8i+7:8i].
//   notch             : per-rotor turnover position, same packing.
//   step              : key-press level, one step per rising edge.
//   run               : free-running, one step per cycle while high.
//   rotor_out         : current positions, 8 bits per rotor.
//   stepped           : pulse, positions changed on the previous edge.
//   wrapped           : pulse, last step returned the stack to the snapshot.
//   busy              : FSM in HOLD or RUN.
// Build option: define ROTOR_DOUBLE_STEP_EN for Enigma double-step advance logic;
// otherwise rotors carry as a plain odometer chain.
module clocked_rotor_bank
    import rotor_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int RADIX      = 26
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load,
    input  logic [NUM_ROTORS*ROTOR_OUT_W-1:0] rotor_init_state,
    input  logic [NUM_ROTORS*ROTOR_OUT_W-1:0] notch,
    input  logic                            step,
    input  logic                            run,
    output logic [NUM_ROTORS*ROTOR_OUT_W-1:0] rotor_out,
    output logic                            stepped,
    output logic                            wrapped,
    output logic                            busy
);

    localparam int STATE_W = (RADIX > 1) ? $clog2(RADIX) : 1;

    state_t                            state_q;
    state_t                            state_d;
    logic                              step_q;
    logic                              stepped_q;
    logic                              do_step;
    logic [NUM_ROTORS*ROTOR_OUT_W-1:0] snap_q;
    logic [NUM_ROTORS-1:0]             adv;
    logic [NUM_ROTORS-1:0]             at_notch;

    // State register. step_q follows the key in every state (and through reset)
    // so a key held across load, RUN or reset never counts as a new press.
    always_ff @(posedge clk) begin
        step_q <= step;
        if (reset) begin
            state_q   <= ST_IDLE;
            stepped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stepped_q <= do_step;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end else if (step && !step_q) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: if (!step) state_d = ST_IDLE;
                ST_RUN:  if (!run)  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        do_step = 1'b0;
        if (!reset && !load) begin
            unique case (state_q)
                ST_IDLE: do_step = run || (step && !step_q);
                ST_RUN:  do_step = run;
                default: do_step = 1'b0;
            endcase
        end
    end

    assign busy = (state_q == ST_HOLD) || (state_q == ST_RUN);

    // Snapshot of the clamped load values, used for the wrap compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                snap_q[i*ROTOR_OUT_W +: ROTOR_OUT_W] <=
                    clamp_pos(rotor_init_state[i*ROTOR_OUT_W +: ROTOR_OUT_W], RADIX);
            end
        end
    end

    // Advance enables, all derived from pre-step positions.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = do_step;
        adv[0] = do_step;
        for (int i = 1; i < NUM_ROTORS; i++) begin
`ifdef ROTOR_DOUBLE_STEP_EN
            // Pawl i engages the notch of rotor i-1; middle rotors sitting on
            // their own notch are dragged along too (double-step anomaly).
            adv[i] = do_step && (at_notch[i-1] || ((i < NUM_ROTORS - 1) && at_notch[i]));
`else
            carry  = carry && at_notch[i-1];
            adv[i] = carry;
`endif
        end
    end

    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_stage
        rotor_stage #(
            .RADIX   (RADIX),
            .STATE_W (STATE_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .init_pos (rotor_init_state[g*ROTOR_OUT_W +: ROTOR_OUT_W]),
            .notch    (notch[g*ROTOR_OUT_W +: ROTOR_OUT_W]),
            .adv      (adv[g]),
            .at_notch (at_notch[g]),
            .pos_out  (rotor_out[g*ROTOR_OUT_W +: ROTOR_OUT_W])
        );
    end

    assign stepped = stepped_q;
    // A load clears stepped_q, so the snapshot compare only matters after a step.
    assign wrapped = stepped_q && (rotor_out == snap_q);

endmodule

// File: tb/tb_clocked_rotor_bank.sv
module tb_clocked_rotor_bank;

    localparam int N = 3;
    localparam int R = 26;

    logic           clk = 1'b0;
    logic           reset, load, step, run;
    logic [N*8-1:0] init_state, notch;
    logic [N*8-1:0] rotor_out;
    logic           stepped, wrapped, busy;

    always #5 clk = ~clk;

    clocked_rotor_bank #(.NUM_ROTORS(N), .RADIX(R)) dut (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .rotor_init_state (init_state),
        .notch            (notch),
        .step             (step),
        .run              (run),
        .rotor_out        (rotor_out),
        .stepped          (stepped),
        .wrapped          (wrapped),
        .busy             (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: positions as integers, mode 0=idle 1=holding key 2=running.
    int mpos[N];
    int msnap[N];
    int mmode;
    bit mkey;
    bit mstepped, mwrapped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  nt[N];
        int  old[N];
        bit  adv[N];
        bit  go;
        bit  carry;
        bit  same;
        for (int i = 0; i < N; i++) nt[i] = int'(notch[i*8 +: 8]);
        go = 1'b0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin mpos[i] = 0; msnap[i] = 0; end
            mmode = 0;
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                mpos[i]  = (int'(init_state[i*8 +: 8]) >= R) ? 0 : int'(init_state[i*8 +: 8]);
                msnap[i] = mpos[i];
            end
            mmode = 0;
        end else begin
            if (mmode == 0) begin
                if (run) begin go = 1; mmode = 2; end
                else if (step && !mkey) begin go = 1; mmode = 1; end
            end else if (mmode == 1) begin
                if (!step) mmode = 0;
            end else begin
                if (run) go = 1; else mmode = 0;
            end
        end
        if (go) begin
            for (int i = 0; i < N; i++) old[i] = mpos[i];
`ifdef ROTOR_DOUBLE_STEP_EN
            adv[0] = 1;
            for (int i = 1; i < N; i++)
                adv[i] = (old[i-1] == nt[i-1]) || ((i < N - 1) && (old[i] == nt[i]));
`else
            carry = 1;
            for (int i = 0; i < N; i++) begin
                adv[i] = carry;
                carry  = carry && (old[i] == nt[i]);
            end
`endif
            for (int i = 0; i < N; i++)
                if (adv[i]) mpos[i] = (old[i] + 1) % R;
            same = 1;
            for (int i = 0; i < N; i++) if (mpos[i] != msnap[i]) same = 0;
            mstepped = 1;
            mwrapped = same;
        end else begin
            mstepped = 0;
            mwrapped = 0;
        end
        mkey = step;
    endtask

    function automatic logic [N*8-1:0] pack3(input int r2, input int r1, input int r0);
        logic [N*8-1:0] v;
        v = '0;
        v[7:0]   = 8'(r0);
        v[15:8]  = 8'(r1);
        v[23:16] = 8'(r2);
        return v;
    endfunction

    task automatic tick();
        logic [N*8-1:0] exp_out;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) exp_out[i*8 +: 8] = 8'(mpos[i]);
        chk("rotor_out", 64'(rotor_out), 64'(exp_out));
        chk("stepped",   64'(stepped),   64'(mstepped));
        chk("wrapped",   64'(wrapped),   64'(mwrapped));
        chk("busy",      64'(busy),      64'(mmode != 0));
    endtask

    initial begin
        int pulses;
        int wraps;
        int wrap_at;

        reset = 1; load = 0; step = 0; run = 0;
        init_state = '0; notch = pack3(25, 25, 25);
        mkey = 0; mmode = 0; mstepped = 0; mwrapped = 0;
        for (int i = 0; i < N; i++) begin mpos[i] = 0; msnap[i] = 0; end
        tick(); tick();
        chk("reset_out", 64'(rotor_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Single press from {2,4,25}.
        reset = 0; load = 1; init_state = pack3(2, 4, 25);
        tick();
        load = 0; step = 1;
        tick();
        chk("press_out", 64'(rotor_out), 64'(pack3(2, 5, 0)));
        chk("press_stepped", 64'(stepped), 64'd1);
        step = 0;
        tick();
        chk("press_stepped_pulse", 64'(stepped), 64'd0);

        // Held key steps once; second press steps again.
        load = 1; init_state = '0;
        tick();
        load = 0; step = 1; pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (stepped) pulses++;
            chk("hold_busy", 64'(busy), 64'd1);
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        step = 0; tick();
        chk("release_busy", 64'(busy), 64'd0);
        step = 1; tick();
        chk("second_press", 64'(rotor_out), 64'(pack3(0, 0, 2)));
        step = 0; tick();

        // Load with a rising key in the same cycle, plus out-of-range load value.
        load = 1; step = 1; init_state = pack3(7, 30, 9);
        tick();
        chk("load_step_out", 64'(rotor_out), 64'(pack3(7, 0, 9)));
        chk("load_step_stepped", 64'(stepped), 64'd0);
        load = 0; tick(); tick();
        chk("load_held_key", 64'(rotor_out), 64'(pack3(7, 0, 9)));
        step = 0; tick();

        // Advance-rule directed check.
        notch = pack3(25, 4, 16);
        load = 1; init_state = pack3(0, 3, 16);
        tick();
        load = 0;
        step = 1; tick(); step = 0; tick();
        chk("adv_step1", 64'(rotor_out), 64'(pack3(0, 4, 17)));
        step = 1; tick(); step = 0; tick();
`ifdef ROTOR_DOUBLE_STEP_EN
        chk("adv_step2", 64'(rotor_out), 64'(pack3(1, 5, 18)));
`else
        chk("adv_step2", 64'(rotor_out), 64'(pack3(0, 4, 18)));
`endif

        // Reset in the middle of RUN.
        notch = pack3(25, 25, 25);
        run = 1;
        for (int k = 0; k < 5; k++) tick();
        reset = 1; tick();
        chk("rst_run_out", 64'(rotor_out), 64'd0);
        chk("rst_run_busy", 64'(busy), 64'd0);
        chk("rst_run_stepped", 64'(stepped), 64'd0);
        reset = 0; run = 0; tick(); tick();
        chk("rst_run_idle", 64'(rotor_out), 64'd0);
        run = 1; tick();
        chk("rst_run_resume", 64'(rotor_out), 64'(pack3(0, 0, 1)));
        run = 0; tick();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 19) == 0);
            run        = ($urandom_range(0, 3) == 0);
            step       = $urandom_range(0, 1);
            init_state = pack3($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0)
                notch = pack3($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30));
            tick();
        end

        // Full odometer sweep.
        reset = 0; step = 0; run = 0;
        notch = pack3(25, 25, 25);
        load = 1; init_state = '0;
        tick();
        load = 0; run = 1; wraps = 0; wrap_at = -1;
        for (int k = 1; k <= R * R * R; k++) begin
            tick();
            if (wrapped) begin wraps++; wrap_at = k; end
        end
        run = 0;
        chk("sweep_wraps", 64'(wraps), 64'd1);
        chk("sweep_wrap_at", 64'(wrap_at), 64'(R * R * R));
        chk("sweep_out", 64'(rotor_out), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
